// File: rtl/mcp3_fifo512x025_ctl.sv
// First-word-fall-through FIFO controller for a 512x25 simple dual-port RAM with a 1-cycle read.
// Words always pass through the RAM and then a 2-entry registered output buffer.
module mcp3_fifo512x025_ctl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_data,
  output logic        ram_wren,
  output logic [8:0]  ram_wrad,
  output logic [24:0] ram_wdata,
  output logic        ram_rden,
  output logic [8:0]  ram_rdad,
  input  logic [24:0] ram_q,
  output logic [9:0]  count,
  output logic        empty,
  output logic        full
);

  logic [8:0]  r_wrad;
  logic [8:0]  r_rdad;
  logic [9:0]  r_ram_count;
  logic        r_rd_inflight;
  logic [1:0]  r_buf_count;
  logic [24:0] r_buf0;
  logic [24:0] r_buf1;

  logic              w_push;
  logic              w_pop;
  logic signed [2:0] w_occ;
  logic [1:0]        w_slot;
  logic [1:0]        w_buf_count_d;
  logic [24:0]       w_buf0_d;
  logic [24:0]       w_buf1_d;
  logic [9:0]        w_ram_count_d;

  // Gating with reset keeps both RAM ports quiet the moment reset asserts.
  assign in_ready  = (r_ram_count != 10'd512);
  assign w_push    = in_valid & in_ready & ~reset;
  assign w_pop     = out_valid & out_ready;
  assign w_occ     = $signed({1'b0, r_buf_count}) + $signed({2'b00, r_rd_inflight})
                   - $signed({2'b00, w_pop});
  assign ram_rden  = ~reset & (r_ram_count != 10'd0) & (w_occ < 3'sd2);

  assign ram_wren  = w_push;
  assign ram_wrad  = r_wrad;
  assign ram_wdata = in_data;
  assign ram_rdad  = r_rdad;

  assign out_valid = (r_buf_count != 2'd0);
  assign out_data  = r_buf0;
  assign count     = r_ram_count + {9'd0, r_rd_inflight} + {8'd0, r_buf_count};
  assign empty     = (count == 10'd0);
  assign full      = ~in_ready;

  always_comb begin
    w_buf0_d      = r_buf0;
    w_buf1_d      = r_buf1;
    w_slot        = r_buf_count - {1'b0, w_pop};
    w_buf_count_d = w_slot + {1'b0, r_rd_inflight};
    w_ram_count_d = r_ram_count + {9'd0, w_push} - {9'd0, ram_rden};
    if (w_pop) begin
      w_buf0_d = r_buf1;
    end
    // The returning read lands in the first free slot after any pop shift.
    if (r_rd_inflight) begin
      if (w_slot == 2'd0) begin
        w_buf0_d = ram_q;
      end else begin
        w_buf1_d = ram_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrad        <= 9'd0;
      r_rdad        <= 9'd0;
      r_ram_count   <= 10'd0;
      r_rd_inflight <= 1'b0;
      r_buf_count   <= 2'd0;
      r_buf0        <= 25'd0;
      r_buf1        <= 25'd0;
    end else begin
      if (w_push) begin
        r_wrad <= r_wrad + 9'd1;
      end
      if (ram_rden) begin
        r_rdad <= r_rdad + 9'd1;
      end
      r_ram_count   <= w_ram_count_d;
      r_rd_inflight <= ram_rden;
      r_buf_count   <= w_buf_count_d;
      r_buf0        <= w_buf0_d;
      r_buf1        <= w_buf1_d;
    end
  end

  a_no_buf_overflow: assert property (@(posedge clk) disable iff (reset)
    !(r_rd_inflight && (r_buf_count == 2'd2) && !w_pop));

  a_no_collision: assert property (@(posedge clk) disable iff (reset)
    !(ram_wren && ram_rden && (ram_wrad == ram_rdad)));

endmodule
